pwl_table_loader: RTL



---
 rtl/pwl_table_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwl_table_loader.sv
// Coefficient-table load sequencer: streams (wdata0, wdata1) pairs into consecutive table addresses.
// Optional PWL_LOAD_CHECK_EN adds a running XOR checksum compared against i_chk_expect at completion.
module pwl_table_loader #(
  parameter int addr_bits = 9,
  parameter int data_bits = 18
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [addr_bits-1:0]        i_base_addr,
  input  logic [addr_bits:0]          i_count,
  input  logic                        i_abort,
  input  logic                        i_s_valid,
  input  logic signed [data_bits-1:0] i_s_data0,
  input  logic signed [data_bits-1:0] i_s_data1,
  output logic                        o_s_ready,
  output logic signed [data_bits-1:0] o_wdata0,
  output logic signed [data_bits-1:0] o_wdata1,
  output logic [addr_bits-1:0]        o_waddr,
  output logic                        o_we,
  output logic                        o_busy,
  output logic                        o_done,
  input  logic [data_bits-1:0]        i_chk_expect,
  output logic                        o_chk_err
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [addr_bits:0] DEPTH = {1'b1, {addr_bits{1'b0}}};

  state_t                r_state;
  logic [addr_bits-1:0]  r_ptr;
  logic [addr_bits:0]    r_rem;
  logic [addr_bits:0]    w_eff;
  logic                  w_acc_start;
  logic                  w_hs;
  logic                  w_last;

  // Requests beyond the table depth saturate so each address is written at most once.
  assign w_eff       = (i_count > DEPTH) ? DEPTH : i_count;
  assign w_acc_start = (r_state == IDLE) && i_start && !i_abort;
  assign o_s_ready   = (r_state == LOAD) && !i_abort;
  assign w_hs        = o_s_ready && i_s_valid;
  assign w_last      = (r_rem == (addr_bits+1)'(1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      o_wdata0 <= '0;
      o_wdata1 <= '0;
      o_waddr  <= '0;
      o_we     <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc_start) begin
            r_ptr <= i_base_addr;
            r_rem <= w_eff;
            if (w_eff == '0) begin
              o_done <= 1'b1;
            end else begin
              r_state <= LOAD;
              o_busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (i_abort) begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
          end else if (w_hs) begin
            o_wdata0 <= i_s_data0;
            o_wdata1 <= i_s_data1;
            o_waddr  <= r_ptr;
            o_we     <= 1'b1;
            r_ptr    <= r_ptr + addr_bits'(1);
            r_rem    <= r_rem - (addr_bits+1)'(1);
            if (w_last) begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PWL_LOAD_CHECK_EN
  logic [data_bits-1:0] r_xor;
  logic [data_bits-1:0] r_chk_exp;
  logic [data_bits-1:0] w_xor_nxt;

  assign w_xor_nxt = r_xor ^ i_s_data0 ^ i_s_data1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_xor     <= '0;
      r_chk_exp <= '0;
      o_chk_err <= 1'b0;
    end else if (w_acc_start) begin
      r_xor     <= '0;
      r_chk_exp <= i_chk_expect;
      // Empty load completes immediately, comparing the cleared checksum.
      o_chk_err <= (w_eff == '0) && (i_chk_expect != '0);
    end else if (w_hs) begin
      r_xor <= w_xor_nxt;
      if (w_last) o_chk_err <= (w_xor_nxt != r_chk_exp);
    end
  end
`else
  logic w_unused_chk;
  assign w_unused_chk = ^i_chk_expect;
  assign o_chk_err    = 1'b0;
`endif

endmodule
